// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
//   fwd_sel_t  : forwarding select encoding (register file / writeback / memory)
//   hz_state_t : memory-wait tracker states
//   REG_ADDR_W_DEF : default register-index width
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding select for one Execute-stage source operand.
//   rs           : source register in Execute
//   rd_m, rd_w   : destination registers in Memory / Writeback
//   reg_write_m/w: those instructions write the register file
//   sel          : FWD_MEM beats FWD_WB beats FWD_REG; x0 is never forwarded
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32 pipeline.
//   Forwarding selects (ForwardAE/ForwardBE), redirect flushes on taken
//   branch/jump, one-cycle load-use stall, and a full-pipeline freeze while
//   the data memory is busy. A RUN/WAIT tracker counts freeze cycles and sets
//   the sticky mem_timeout flag when memory looks stuck.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE   register indices in Decode / Execute
//   RdM/RdW, RegWriteM/W       writers in Memory / Writeback
//   LoadE, BranchE, JumpE, cond_trueE   Execute-stage control
//   MemReqM, mem_ready         memory access in flight / completing
//   ForwardAE/BE               operand selects (00 RF, 01 ResultW, 10 ALUResultM)
//   StallF/D/E/M, FlushD/E/W   pipeline register controls (combinational)
//   mem_timeout                sticky stuck-memory flag
//   stall_cycles, flush_count  perf counters
//   dbg_state                  current tracker state
// Optional feature: define HAZARD_PERF_EN to build the perf counters;
// otherwise both counter outputs are tied to zero.
// Handshake: none; every control output is valid in the same cycle as the
// inputs that cause it.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int WAIT_MAX   = 64,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  cond_trueE,
  input  logic                  MemReqM,
  input  logic                  mem_ready,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  mem_timeout,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_count,
  output hz_state_t             dbg_state
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  fwd_sel_t        fwd_a, fwd_b;
  logic            taken, lu, frz;
  hz_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign dbg_state = state;

  assign taken = (BranchE && cond_trueE) || JumpE;
  assign lu    = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign frz   = MemReqM && !mem_ready;

  // Priority: freeze > redirect > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (frz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (taken) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Memory-wait tracker. wait_cnt holds the number of completed WAIT cycles;
  // mem_timeout is set on the edge where wait_cnt becomes WAIT_MAX-1 with the
  // freeze still active, so it is visible after WAIT_MAX frozen cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (frz) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (!frz) begin
            state <= RUN;
          end else begin
            if (wait_cnt < CNT_W'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= CNT_W'(WAIT_MAX - 2)) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Only redirect-caused FlushE counts as a flush; load-use bubbles do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (StallF) stall_cycles <= stall_cycles + 1'b1;
      if (taken && !frz) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
